// File: rtl/logic_result_buffer.sv
// ---------------------------------------------------------------------------
// logic_result_buffer
//
// Two-entry in-order result buffer between a logical unit (NOT/AND/OR/XOR)
// and register writeback. Each entry holds {data, dest, zero, neg} and, when
// LOGIC_RESULT_PARITY_EN is defined, a parity bit. The flags are computed once,
// at push time, so the writeback side sees them without any extra logic depth.
//
// Optional feature macro: LOGIC_RESULT_PARITY_EN
//   When defined, adds output out_par and per-entry parity storage.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous discard of every buffered entry
//   in_valid   in   upstream result present
//   in_ready   out  buffer can accept a result (registered state only)
//   in_data    in   result data            [DATA_W]
//   in_dest    in   destination register   [DEST_W]
//   out_valid  out  head entry available
//   out_ready  in   writeback consumes head entry
//   out_data   out  head data, 0 when empty
//   out_dest   out  head destination, 0 when empty
//   out_zero   out  head data == 0, 0 when empty
//   out_neg    out  head data MSB, 0 when empty
//   count      out  number of valid entries (0..2)
//   out_par    out  XOR of head data bits, 0 when empty (parity builds only)
// ---------------------------------------------------------------------------
module logic_result_buffer #(
   parameter int DATA_W = 16,
   parameter int DEST_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DEST_W-1:0] in_dest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [DEST_W-1:0] out_dest,
   output logic              out_zero,
   output logic              out_neg,
   output logic [1:0]        count
`ifdef LOGIC_RESULT_PARITY_EN
   ,
   output logic              out_par
`endif
);

   // Flag helpers, evaluated on the incoming result before it is stored.
   function automatic logic calc_zero(input logic signed [DATA_W-1:0] d);
      return (d == '0);
   endfunction

   function automatic logic calc_neg(input logic signed [DATA_W-1:0] d);
      return (d < 0);
   endfunction

`ifdef LOGIC_RESULT_PARITY_EN
   function automatic logic calc_par(input logic signed [DATA_W-1:0] d);
      return ^d;
   endfunction
`endif

   // Control state: occupancy and 1-bit pointers wrapping modulo 2.
   logic [1:0] cnt_p0;
   logic       wr_ptr_p0;
   logic       rd_ptr_p0;

   // Entry storage. Not reset: every read is masked by the occupancy count.
   logic signed [DATA_W-1:0] data_p0 [2];
   logic        [DEST_W-1:0] dest_p0 [2];
   logic                     zero_p0 [2];
   logic                     neg_p0  [2];
`ifdef LOGIC_RESULT_PARITY_EN
   logic                     par_p0  [2];
`endif

   logic signed [DATA_W-1:0] in_data_s;
   logic                     push;
   logic                     pop;
   logic                     vld_p0;

   assign in_data_s = $signed(in_data);
   assign vld_p0    = (cnt_p0 != 2'd0);
   // in_ready comes only from the registered count, so a pop frees space
   // for the next cycle rather than creating an out_ready -> in_ready path.
   assign in_ready  = (cnt_p0 != 2'd2);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = vld_p0 && out_ready && !flush;

   // ---- input -> storage boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p0    <= 2'd0;
         wr_ptr_p0 <= 1'b0;
         rd_ptr_p0 <= 1'b0;
      end else if (flush) begin
         cnt_p0    <= 2'd0;
         wr_ptr_p0 <= 1'b0;
         rd_ptr_p0 <= 1'b0;
      end else begin
         if (push) wr_ptr_p0 <= ~wr_ptr_p0;
         if (pop)  rd_ptr_p0 <= ~rd_ptr_p0;
         case ({push, pop})
            2'b10:   cnt_p0 <= cnt_p0 + 2'd1;
            2'b01:   cnt_p0 <= cnt_p0 - 2'd1;
            default: cnt_p0 <= cnt_p0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_p0[wr_ptr_p0] <= in_data_s;
         dest_p0[wr_ptr_p0] <= in_dest;
         zero_p0[wr_ptr_p0] <= calc_zero(in_data_s);
         neg_p0[wr_ptr_p0]  <= calc_neg(in_data_s);
`ifdef LOGIC_RESULT_PARITY_EN
         par_p0[wr_ptr_p0]  <= calc_par(in_data_s);
`endif
      end
   end

   // ---- storage -> writeback boundary ----
   always_comb begin
      out_valid = vld_p0;
      count     = cnt_p0;
      out_data  = '0;
      out_dest  = '0;
      out_zero  = 1'b0;
      out_neg   = 1'b0;
`ifdef LOGIC_RESULT_PARITY_EN
      out_par   = 1'b0;
`endif
      if (vld_p0) begin
         out_data = $unsigned(data_p0[rd_ptr_p0]);
         out_dest = dest_p0[rd_ptr_p0];
         out_zero = zero_p0[rd_ptr_p0];
         out_neg  = neg_p0[rd_ptr_p0];
`ifdef LOGIC_RESULT_PARITY_EN
         out_par  = par_p0[rd_ptr_p0];
`endif
      end
   end

endmodule

// File: tb/tb_logic_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_logic_result_buffer
//
// Directed testbench for logic_result_buffer. Each scenario task drives its
// stimulus and compares outputs against hand-computed values. Inputs change
// 1 time unit after the rising edge; outputs are sampled at that point too.
// Parity scenario is built only when LOGIC_RESULT_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_logic_result_buffer;

   localparam int DATA_W = 16;
   localparam int DEST_W = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [DEST_W-1:0] in_dest;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [DEST_W-1:0] out_dest;
   logic              out_zero;
   logic              out_neg;
   logic [1:0]        count;
`ifdef LOGIC_RESULT_PARITY_EN
   logic              out_par;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   logic_result_buffer #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_dest  (out_dest),
      .out_zero  (out_zero),
      .out_neg   (out_neg),
      .count     (count)
`ifdef LOGIC_RESULT_PARITY_EN
      ,
      .out_par   (out_par)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      in_data   = '0;
      in_dest   = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
      total_cnt++; if (count !== 2'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
      total_cnt++; if (out_data !== 16'h0000) $display("FAIL reset_out_data got %h want 0000", out_data); else pass_cnt++;
      total_cnt++; if (out_dest !== 3'd0) $display("FAIL reset_out_dest got %0d want 0", out_dest); else pass_cnt++;
      total_cnt++; if ({out_zero, out_neg} !== 2'b00) $display("FAIL reset_flags got %b want 00", {out_zero, out_neg}); else pass_cnt++;
   endtask

   task automatic test_single_push();
      in_valid = 1'b1; in_data = 16'hFFF4; in_dest = 3'd3;
      step();
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL push1_out_valid got %b want 1", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 16'hFFF4) $display("FAIL push1_out_data got %h want fff4", out_data); else pass_cnt++;
      total_cnt++; if (out_dest !== 3'd3) $display("FAIL push1_out_dest got %0d want 3", out_dest); else pass_cnt++;
      total_cnt++; if (out_neg !== 1'b1) $display("FAIL push1_out_neg got %b want 1", out_neg); else pass_cnt++;
      total_cnt++; if (out_zero !== 1'b0) $display("FAIL push1_out_zero got %b want 0", out_zero); else pass_cnt++;
      total_cnt++; if (count !== 2'd1) $display("FAIL push1_count got %0d want 1", count); else pass_cnt++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total_cnt++; if (count !== 2'd0) $display("FAIL drain1_count got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (out_data !== 16'h0000) $display("FAIL drain1_out_data got %h want 0000", out_data); else pass_cnt++;
   endtask

   task automatic test_fill();
      in_valid = 1'b1; in_data = 16'h0000; in_dest = 3'd1;
      step();
      in_data = 16'h0F0F; in_dest = 3'd2;
      step();
      total_cnt++; if (count !== 2'd2) $display("FAIL fill_count got %0d want 2", count); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b want 0", in_ready); else pass_cnt++;
      total_cnt++; if (out_data !== 16'h0000) $display("FAIL fill_head_data got %h want 0000", out_data); else pass_cnt++;
      total_cnt++; if (out_zero !== 1'b1) $display("FAIL fill_head_zero got %b want 1", out_zero); else pass_cnt++;
      total_cnt++; if (out_dest !== 3'd1) $display("FAIL fill_head_dest got %0d want 1", out_dest); else pass_cnt++;
      // Third push attempt while full must be ignored.
      in_data = 16'hAAAA; in_dest = 3'd7;
      step();
      in_valid = 1'b0;
      total_cnt++; if (count !== 2'd2) $display("FAIL full_push_count got %0d want 2", count); else pass_cnt++;
      total_cnt++; if (out_data !== 16'h0000) $display("FAIL full_push_head got %h want 0000", out_data); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL pop_same_cycle_in_ready got %b want 0", in_ready); else pass_cnt++;
      step();
      out_ready = 1'b0;
      total_cnt++; if (out_data !== 16'h0F0F) $display("FAIL pop_head_data got %h want 0f0f", out_data); else pass_cnt++;
      total_cnt++; if (out_dest !== 3'd2) $display("FAIL pop_head_dest got %0d want 2", out_dest); else pass_cnt++;
      total_cnt++; if (count !== 2'd1) $display("FAIL pop_count got %0d want 1", count); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL pop_in_ready got %b want 1", in_ready); else pass_cnt++;
      in_valid = 1'b1; in_data = 16'h1234; in_dest = 3'd5; out_ready = 1'b1;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      total_cnt++; if (count !== 2'd1) $display("FAIL simul_count got %0d want 1", count); else pass_cnt++;
      total_cnt++; if (out_data !== 16'h1234) $display("FAIL simul_head_data got %h want 1234", out_data); else pass_cnt++;
      total_cnt++; if (out_dest !== 3'd5) $display("FAIL simul_head_dest got %0d want 5", out_dest); else pass_cnt++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total_cnt++; if (count !== 2'd0) $display("FAIL simul_drain_count got %0d want 0", count); else pass_cnt++;
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_data = 16'h1111; in_dest = 3'd1;
      step();
      in_data = 16'h2222; in_dest = 3'd2;
      step();
      total_cnt++; if (count !== 2'd2) $display("FAIL preflush_count got %0d want 2", count); else pass_cnt++;
      flush = 1'b1; in_data = 16'h3333; in_dest = 3'd3; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      total_cnt++; if (count !== 2'd0) $display("FAIL flush_count got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 16'h0000) $display("FAIL flush_out_data got %h want 0000", out_data); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", in_ready); else pass_cnt++;
      in_valid = 1'b1; in_data = 16'h4444; in_dest = 3'd4;
      step();
      in_valid = 1'b0;
      total_cnt++; if (out_data !== 16'h4444) $display("FAIL postflush_head got %h want 4444", out_data); else pass_cnt++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; in_data = 16'h8555; in_dest = 3'd6;
      step();
      total_cnt++; if (count !== 2'd1) $display("FAIL premid_count got %0d want 1", count); else pass_cnt++;
      rst = 1'b1; in_data = 16'h6666; in_dest = 3'd7;
      step();
      rst = 1'b0; in_valid = 1'b0;
      total_cnt++; if (count !== 2'd0) $display("FAIL midrst_count got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", in_ready); else pass_cnt++;
      total_cnt++; if (out_data !== 16'h0000) $display("FAIL midrst_out_data got %h want 0000", out_data); else pass_cnt++;
      total_cnt++; if (out_dest !== 3'd0) $display("FAIL midrst_out_dest got %0d want 0", out_dest); else pass_cnt++;
      total_cnt++; if ({out_zero, out_neg} !== 2'b00) $display("FAIL midrst_flags got %b want 00", {out_zero, out_neg}); else pass_cnt++;
      step();
      total_cnt++; if (count !== 2'd0) $display("FAIL midrst_hold_count got %0d want 0", count); else pass_cnt++;
   endtask

`ifdef LOGIC_RESULT_PARITY_EN
   task automatic test_parity();
      total_cnt++; if (out_par !== 1'b0) $display("FAIL par_empty got %b want 0", out_par); else pass_cnt++;
      in_valid = 1'b1; in_data = 16'h0007; in_dest = 3'd1;
      step();
      in_data = 16'h0003; in_dest = 3'd2;
      total_cnt++; if (out_par !== 1'b1) $display("FAIL par_0007 got %b want 1", out_par); else pass_cnt++;
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total_cnt++; if (out_data !== 16'h0003) $display("FAIL par_head got %h want 0003", out_data); else pass_cnt++;
      total_cnt++; if (out_par !== 1'b0) $display("FAIL par_0003 got %b want 0", out_par); else pass_cnt++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total_cnt++; if (out_par !== 1'b0) $display("FAIL par_drained got %b want 0", out_par); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_single_push();
      test_fill();
      test_back_to_back();
      test_flush();
      test_reset_mid();
`ifdef LOGIC_RESULT_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/logic_result_buffer.md
LOGIC_RESULT_BUFFER -- requirements
Module: logic_result_buffer

Interface
REQ-001 Parameter DATA_W, default 16, result data width in bits.
REQ-002 Parameter DEST_W, default 3, destination register index width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  upstream logical unit presents a result.
REQ-007 in_ready  output  1  buffer can accept a result this cycle.
REQ-008 in_data  input  DATA_W  result from logical unit (NOT/AND/OR/XOR).
REQ-009 in_dest  input  DEST_W  destination register index for the result.
REQ-010 out_valid  output  1  head entry available to writeback.
REQ-011 out_ready  input  1  writeback consumes head entry this cycle.
REQ-012 out_data  output  DATA_W  head entry data.
REQ-013 out_dest  output  DEST_W  head entry destination index.
REQ-014 out_zero  output  1  head entry data equals zero.
REQ-015 out_neg  output  1  head entry data MSB.
REQ-016 count  output  2  number of valid entries (0..2).

Function
REQ-017 The block SHALL be a 2-entry in-order FIFO of {data, dest, zero, neg}; flags are computed from in_data at push time.
REQ-018 in_ready SHALL equal (count != 2) and SHALL depend only on registered state, never combinationally on out_ready.
REQ-019 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-020 out_valid SHALL equal (count != 0); out_* fields SHALL present the oldest entry.
REQ-021 Latency SHALL be 1 cycle: a push into an empty buffer at edge N makes out_valid=1 with that entry after edge N.
REQ-022 Simultaneous push and pop with count=1 SHALL leave count=1 with the pushed entry at the head next cycle.
REQ-023 With count=2, in_ready=0; a pop SHALL make in_ready=1 the following cycle, not the same cycle.
REQ-024 Pop with count=0 is impossible (out_valid=0); push with count=2 is impossible (in_ready=0); count SHALL never wrap.
REQ-025 Read/write pointers SHALL be 1 bit each and wrap modulo 2.
REQ-026 flush SHALL have priority over push and pop: next cycle count=0, out_valid=0, in_ready=1, pointers 0.
REQ-027 out_data, out_dest, out_zero, out_neg SHALL read 0 whenever count=0.

Reset
REQ-028 rst SHALL take priority over flush and all handshakes and is sampled only on the rising clk edge.
REQ-029 After reset: count=0, out_valid=0, in_ready=1, out_data=0, out_dest=0, out_zero=0, out_neg=0, pointers 0.
REQ-030 Reset asserted mid-operation SHALL discard all entries in that cycle; no partially accepted result survives.

Configuration
REQ-031 Macro LOGIC_RESULT_PARITY_EN SHALL, when defined, add output out_par (1 bit) = XOR of all head-entry data bits, stored per entry at push time, 0 when count=0 and after reset.
REQ-032 Without LOGIC_RESULT_PARITY_EN, the out_par port and its storage SHALL not exist; all other behaviour is identical.

Verification
REQ-033 Reset then push in_data=0xFFF4, in_dest=3 -> next cycle out_valid=1, out_data=0xFFF4, out_dest=3, out_neg=1, out_zero=0, count=1.
REQ-034 Push 0x0000 then 0x0F0F with out_ready=0 -> count=2, in_ready=0, head 0x0000 with out_zero=1; third push attempt ignored.
REQ-035 Full buffer, out_ready=1 one cycle -> head becomes 0x0F0F, count=1, in_ready=1 next cycle; then simultaneous push 0x1234 and pop -> count=1, head 0x1234.
REQ-036 count=2 then flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_data=0, no entry accepted.
REQ-037 rst asserted while count=1 and in_valid=1 -> next cycle all outputs at reset values, count=0.
REQ-038 With LOGIC_RESULT_PARITY_EN: push 0x0007 -> out_par=1; push 0x0003 -> out_par=0 when at head.
